// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer: merges the ALU result (source A, no backpressure, top
// priority) and the long-latency unit result (source B, buffered in a FIFO)
// into the single registered regfile write port.
// Optional feature: define WB_BUSY_MASK_EN to add the busy_mask output that
// flags registers with a pending (buffered or staged) write.
module regfile_wb_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_valid,
  input  logic [ADDR_WIDTH-1:0]      a_rd,
  input  logic [DATA_WIDTH-1:0]      a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [ADDR_WIDTH-1:0]      b_rd,
  input  logic [DATA_WIDTH-1:0]      b_data,
  output logic                       RegWrite,
  output logic [ADDR_WIDTH-1:0]      WriteRegister,
  output logic [DATA_WIDTH-1:0]      WriterData,
  output logic [$clog2(DEPTH):0]     fifo_count
`ifdef WB_BUSY_MASK_EN
  ,
  output logic [31:0]                busy_mask
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] mem_rd_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  regwrite_q, regwrite_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  a_wr, push, pop;

  // Handshake and arbitration: A wins, FIFO drains only on A-idle cycles.
  // b_ready comes from the registered count, so a full FIFO refuses B even
  // while it pops; rd=0 B results complete the handshake but are dropped.
  always_comb begin
    b_ready = (count_q != CNT_W'(DEPTH));
    a_wr    = a_valid && (a_rd != '0);
    push    = b_valid && b_ready && (b_rd != '0);
    pop     = !a_wr && (count_q != '0);
  end

  // Next-state for FIFO storage, pointers, count and the output stage.
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (push) begin
      mem_rd_d[wr_ptr_q]   = b_rd;
      mem_data_d[wr_ptr_q] = b_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (a_wr) begin
      regwrite_d = 1'b1;
      wreg_d     = a_rd;
      wdata_d    = a_data;
    end else if (pop) begin
      regwrite_d = 1'b1;
      wreg_d     = mem_rd_q[rd_ptr_q];
      wdata_d    = mem_data_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
  end

  // Control and output registers; reset discards buffered and staged writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  // FIFO payload storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriterData    = wdata_q;
  assign fifo_count    = count_q;

`ifdef WB_BUSY_MASK_EN
  logic [DEPTH-1:0] ent_vld;

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    ent_vld = '0;
    for (int e = 0; e < DEPTH; e++)
      ent_vld[e] = CNT_W'(PTR_W'(PTR_W'(e) - rd_ptr_q)) < count_q;
  end

  // Pending-write mask over buffered entries plus the staged write; x0 never set.
  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < 32; r++) begin
      busy_mask[r] = regwrite_q && (wreg_q == ADDR_WIDTH'(r));
      for (int e = 0; e < DEPTH; e++)
        if (ent_vld[e] && (mem_rd_q[e] == ADDR_WIDTH'(r))) busy_mask[r] = 1'b1;
    end
  end
`endif

endmodule
